master_fsm_multi: RTL

//  Parametrised mode sequencer for the bicycle light: cycles OFF/ON/OFF/FLASH0/OFF/FLASH1/...,

---
 rtl/master_fsm_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/master_fsm_multi.sv
// master_fsm_multi: bicycle-light mode sequencer.
// Steps through OFF/ON/OFF/FLASH0/OFF/FLASH1/... in both directions.
// Drives the output mux select and per-channel speed-shift pulses.
// Tracks a saturating speed level for each flash channel.
// An optional idle timeout forces the light back to OFF.
module master_fsm_multi #(
   parameter  int NUM_FLASH  = 2,
   parameter  int SPEED_W    = 3,
   parameter  int SPEED_INIT = 3,
   parameter  int TIMEOUT    = 0,
   parameter  int TO_W       = 24,
   localparam int NS         = 2 * (NUM_FLASH + 1),
   localparam int SW         = $clog2(NS),
   localparam int SEL_W      = $clog2(NUM_FLASH + 2)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          next,
   input  logic                          prev,
   input  logic                          up_button,
   input  logic                          down_button,
   output logic [SW-1:0]                 state,
   output logic [SEL_W-1:0]              out,
   output logic [NUM_FLASH-1:0]          shift_right,
   output logic [NUM_FLASH-1:0]          shift_left,
   output logic [NUM_FLASH*SPEED_W-1:0]  speed_level,
   output logic                          timed_out
);

   // The state register is a plain index; the mode class is decoded from it.
   typedef enum logic [1:0] {
      M_OFF,
      M_ON,
      M_FLASH,
      M_ILLEGAL
   } mode_t;

   mode_t           mode;
   logic [SW-1:0]   flash_k;
   logic [TO_W-1:0] to_cnt;
   logic            any_btn;
   logic            fire;

   // Decode the mode class, active flash channel, mux select and timeout condition.
   always_comb begin
      mode    = M_OFF;
      flash_k = '0;
      out     = '0;
      any_btn = next | prev | up_button | down_button;
      // The widened compare stays correct when NS is an exact power of two.
      if ({1'b0, state} >= (SW + 1)'(NS)) begin
         mode = M_ILLEGAL;
      end else if (!state[0]) begin
         mode = M_OFF;
      end else if (state == SW'(1)) begin
         mode = M_ON;
         out  = SEL_W'(1);
      end else begin
         mode    = M_FLASH;
         flash_k = (state - SW'(3)) >> 1;
         out     = SEL_W'(({1'b0, state} + 1'b1) >> 1);
      end
      fire = (TIMEOUT > 0) && (mode == M_ON || mode == M_FLASH) && !any_btn &&
             (to_cnt == TO_W'(TIMEOUT - 1));
   end

   // Generate speed-shift pulses for the active flash channel only, stopping at saturation.
   always_comb begin
      shift_right = '0;
      shift_left  = '0;
      if (mode == M_FLASH) begin
         for (int unsigned k = 0; k < NUM_FLASH; k++) begin
            if (SW'(k) == flash_k) begin
               shift_right[k] = up_button & ~down_button &
                                (speed_level[k*SPEED_W +: SPEED_W] != '1);
               shift_left[k]  = down_button & ~up_button &
                                (speed_level[k*SPEED_W +: SPEED_W] != '0);
            end
         end
      end
   end

   // Mode navigation, idle timer and auto-off pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= '0;
         to_cnt    <= '0;
         timed_out <= 1'b0;
      end else begin
         timed_out <= 1'b0;
         if (mode == M_ILLEGAL) begin
            state <= '0;
         end else if (fire) begin
            state     <= '0;
            timed_out <= 1'b1;
         end else if (next & ~prev) begin
            state <= (state == SW'(NS - 1)) ? '0 : state + 1'b1;
         end else if (prev & ~next) begin
            state <= (state == '0) ? SW'(NS - 1) : state - 1'b1;
         end

         if (TIMEOUT == 0 || mode == M_OFF || mode == M_ILLEGAL || any_btn || fire) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   // Per-channel speed levels; they persist across mode changes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_level <= {NUM_FLASH{SPEED_W'(SPEED_INIT)}};
      end else begin
         for (int unsigned k = 0; k < NUM_FLASH; k++) begin
            if (shift_right[k]) begin
               speed_level[k*SPEED_W +: SPEED_W] <= speed_level[k*SPEED_W +: SPEED_W] + 1'b1;
            end else if (shift_left[k]) begin
               speed_level[k*SPEED_W +: SPEED_W] <= speed_level[k*SPEED_W +: SPEED_W] - 1'b1;
            end
         end
      end
   end

endmodule
